// File: rtl/axis_elastic_buffer.sv
// AXI-Stream style elastic buffer: circular storage of {last, data} beats with an
// optional zero-latency bypass when empty (REG_OUT=0) and a registered upstream ready.
module axis_elastic_buffer #(
  parameter int DWIDTH  = 8,
  parameter int DEPTH   = 4,
  parameter bit REG_OUT = 1'b0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [DWIDTH-1:0]          i_data,
  input  logic                       i_last,
  input  logic                       i_valid,
  output logic                       o_ready,
  output logic [DWIDTH-1:0]          o_data,
  output logic                       o_last,
  output logic                       o_valid,
  input  logic                       i_ready,
  output logic [$clog2(DEPTH+1)-1:0] o_count
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);

  logic [DWIDTH:0] mem_r [DEPTH];
  logic [PW-1:0]   wr_ptr_r;
  logic [PW-1:0]   rd_ptr_r;
  logic [CW-1:0]   count_r;
  logic [CW-1:0]   count_nxt_s;
  logic            ready_r;
  logic            empty_s;
  logic            bypass_mode_s;
  logic            push_s;
  logic            pop_s;
  logic            wr_en_s;
  logic            rd_en_s;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] ptr);
    if (ptr == LAST_PTR) begin
      return {PW{1'b0}};
    end else begin
      return ptr + PW'(1);
    end
  endfunction

  assign empty_s       = (count_r == {CW{1'b0}});
  assign bypass_mode_s = (REG_OUT == 1'b0) && empty_s;
  assign push_s        = i_valid && ready_r;
  assign pop_s         = o_valid && i_ready;
  // A beat that is taken downstream in the same cycle it arrives never touches storage.
  assign wr_en_s       = push_s && !(bypass_mode_s && i_ready);
  assign rd_en_s       = pop_s && !empty_s;

  // Downstream view: bypass of the upstream beat when empty, else the head entry.
  always_comb begin
    o_valid = 1'b0;
    o_data  = {DWIDTH{1'b0}};
    o_last  = 1'b0;
    if (rst) begin
      o_valid = 1'b0;
    end else if (bypass_mode_s) begin
      o_valid = push_s;
      o_data  = i_data;
      o_last  = i_last;
    end else if (!empty_s) begin
      o_valid = 1'b1;
      {o_last, o_data} = mem_r[rd_ptr_r];
    end else begin
      o_valid = 1'b0;
    end
  end

  // Occupancy after this cycle's write and read.
  always_comb begin
    count_nxt_s = count_r;
    case ({wr_en_s, rd_en_s})
      2'b10:   count_nxt_s = count_r + CW'(1);
      2'b01:   count_nxt_s = count_r - CW'(1);
      default: count_nxt_s = count_r;
    endcase
  end

  // Pointers, occupancy and the registered upstream ready.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_r <= {PW{1'b0}};
      rd_ptr_r <= {PW{1'b0}};
      count_r  <= {CW{1'b0}};
      ready_r  <= 1'b0;
    end else begin
      if (wr_en_s) begin
        wr_ptr_r <= ptr_inc(wr_ptr_r);
      end
      if (rd_en_s) begin
        rd_ptr_r <= ptr_inc(rd_ptr_r);
      end
      count_r <= count_nxt_s;
      ready_r <= (count_nxt_s < FULL_CNT);
    end
  end

  // Storage array; contents are irrelevant until written, so no reset.
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      mem_r[wr_ptr_r] <= {i_last, i_data};
    end
  end

  assign o_ready = ready_r;
  assign o_count = count_r;

endmodule

// File: tb/tb_axis_elastic_buffer.sv
// Self-checking bench for axis_elastic_buffer: directed scenarios on DEPTH=4 with
// both output modes, plus a randomized run on DEPTH=8 against a queue reference.
module tb_axis_elastic_buffer;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] i_data = 8'h00;
  logic       i_last = 1'b0;
  logic       i_valid = 1'b0;
  logic       i_ready = 1'b0;

  logic       a_ready, a_last, a_valid;
  logic [7:0] a_data;
  logic [2:0] a_count;
  logic       b_ready, b_last, b_valid;
  logic [7:0] b_data;
  logic [2:0] b_count;
  logic       c_ready, c_last, c_valid;
  logic [7:0] c_data;
  logic [3:0] c_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  axis_elastic_buffer #(.DWIDTH(8), .DEPTH(4), .REG_OUT(1'b0)) u_a (
    .clk(clk), .rst(rst), .i_data(i_data), .i_last(i_last), .i_valid(i_valid),
    .o_ready(a_ready), .o_data(a_data), .o_last(a_last), .o_valid(a_valid),
    .i_ready(i_ready), .o_count(a_count));

  axis_elastic_buffer #(.DWIDTH(8), .DEPTH(4), .REG_OUT(1'b1)) u_b (
    .clk(clk), .rst(rst), .i_data(i_data), .i_last(i_last), .i_valid(i_valid),
    .o_ready(b_ready), .o_data(b_data), .o_last(b_last), .o_valid(b_valid),
    .i_ready(i_ready), .o_count(b_count));

  axis_elastic_buffer #(.DWIDTH(8), .DEPTH(8), .REG_OUT(1'b0)) u_c (
    .clk(clk), .rst(rst), .i_data(i_data), .i_last(i_last), .i_valid(i_valid),
    .o_ready(c_ready), .o_data(c_data), .o_last(c_last), .o_valid(c_valid),
    .i_ready(i_ready), .o_count(c_count));

  task automatic do_reset();
    rst = 1'b1;
    i_valid = 1'b0; i_data = 8'h00; i_last = 1'b0; i_ready = 1'b0;
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    #1 rst = 1'b1;
    i_valid = 1'b1; i_data = 8'hFF; i_last = 1'b1;
    #1;
    checks++; if ({a_ready, a_valid, a_count, a_data, a_last} !== 14'h0) begin
      errors++; $display("FAIL reset_a got rdy=%b vld=%b cnt=%0d data=%h last=%b exp all zero", a_ready, a_valid, a_count, a_data, a_last);
    end
    checks++; if ({b_ready, b_valid, b_count, b_data, b_last} !== 14'h0) begin
      errors++; $display("FAIL reset_b got rdy=%b vld=%b cnt=%0d data=%h last=%b exp all zero", b_ready, b_valid, b_count, b_data, b_last);
    end
    repeat (2) @(posedge clk);
    i_valid = 1'b0; i_data = 8'h00; i_last = 1'b0;
    #2 rst = 1'b0;
    #1;
    checks++; if (a_ready !== 1'b0) begin
      errors++; $display("FAIL ready_before_edge got %b exp 0", a_ready);
    end
    @(posedge clk); #1;
    checks++; if (a_ready !== 1'b1 || c_ready !== 1'b1) begin
      errors++; $display("FAIL ready_first_edge got a=%b c=%b exp 1", a_ready, c_ready);
    end
  endtask

  task automatic test_bypass();
    do_reset();
    i_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      i_valid = 1'b1; i_data = 8'(i); i_last = (i == 8);
      @(negedge clk);
      checks++; if (a_valid !== 1'b1 || a_data !== 8'(i) || a_last !== (i == 8) || a_count !== 3'd0) begin
        errors++; $display("FAIL bypass_beat got vld=%b data=%h last=%b cnt=%0d exp 1 %h %b 0", a_valid, a_data, a_last, a_count, 8'(i), (i == 8));
      end
      @(posedge clk); #1;
    end
    i_valid = 1'b0;
    checks++; if (a_count !== 3'd0) begin
      errors++; $display("FAIL bypass_count got %0d exp 0", a_count);
    end
  endtask

  task automatic test_fill_drain();
    do_reset();
    i_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      i_valid = 1'b1; i_data = 8'hA0 + 8'(i); i_last = (i == 3);
      @(negedge clk);
      checks++; if (a_ready !== 1'b1) begin
        errors++; $display("FAIL fill_ready got %b exp 1 at beat %0d", a_ready, i);
      end
      @(posedge clk); #1;
    end
    i_valid = 1'b0; i_last = 1'b0;
    checks++; if (a_count !== 3'd4 || a_ready !== 1'b0 || a_valid !== 1'b1 || a_data !== 8'hA0) begin
      errors++; $display("FAIL full_state got cnt=%0d rdy=%b vld=%b data=%h exp 4 0 1 a0", a_count, a_ready, a_valid, a_data);
    end
    i_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++; if (a_valid !== 1'b1 || a_data !== 8'hA0 + 8'(i) || a_last !== (i == 3) || a_ready !== (i != 0)) begin
        errors++; $display("FAIL drain_beat got vld=%b data=%h last=%b rdy=%b exp 1 %h %b %b", a_valid, a_data, a_last, a_ready, 8'hA0 + 8'(i), (i == 3), (i != 0));
      end
      @(posedge clk); #1;
    end
    checks++; if (a_count !== 3'd0 || a_valid !== 1'b0) begin
      errors++; $display("FAIL drain_empty got cnt=%0d vld=%b exp 0 0", a_count, a_valid);
    end
  endtask

  task automatic test_reg_out();
    do_reset();
    i_ready = 1'b1; i_valid = 1'b1; i_data = 8'h55; i_last = 1'b1;
    @(negedge clk);
    checks++; if (b_valid !== 1'b0) begin
      errors++; $display("FAIL regout_same_cycle got vld=%b exp 0", b_valid);
    end
    @(posedge clk); #1;
    i_valid = 1'b0; i_data = 8'h00; i_last = 1'b0;
    checks++; if (b_valid !== 1'b1 || b_data !== 8'h55 || b_last !== 1'b1) begin
      errors++; $display("FAIL regout_next_cycle got vld=%b data=%h last=%b exp 1 55 1", b_valid, b_data, b_last);
    end
    @(posedge clk); #1;
    checks++; if (b_valid !== 1'b0 || b_count !== 3'd0) begin
      errors++; $display("FAIL regout_drained got vld=%b cnt=%0d exp 0 0", b_valid, b_count);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    i_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      i_valid = 1'b1; i_data = 8'h10 + 8'(i);
      @(posedge clk); #1;
    end
    i_valid = 1'b0;
    checks++; if (a_count !== 3'd4 || b_count !== 3'd4) begin
      errors++; $display("FAIL pre_reset_full got a=%0d b=%0d exp 4", a_count, b_count);
    end
    @(negedge clk); #1 rst = 1'b1; #1;
    checks++; if ({a_valid, a_ready, a_count, a_data} !== 13'h0 || {b_valid, b_ready, b_count, b_data} !== 13'h0) begin
      errors++; $display("FAIL mid_reset got a=%b%b%0d/%h b=%b%b%0d/%h exp zeros", a_valid, a_ready, a_count, a_data, b_valid, b_ready, b_count, b_data);
    end
    @(posedge clk); #3 rst = 1'b0;
    @(posedge clk); #1;
    i_valid = 1'b1; i_data = 8'h7F; i_last = 1'b0;
    @(posedge clk); #1;
    i_valid = 1'b0;
    checks++; if (a_count !== 3'd1 || a_valid !== 1'b1 || a_data !== 8'h7F || b_data !== 8'h7F || b_count !== 3'd1) begin
      errors++; $display("FAIL post_reset_beat got a=%0d/%b/%h b=%0d/%h exp 1/1/7f", a_count, a_valid, a_data, b_count, b_data);
    end
    i_ready = 1'b1;
    @(posedge clk); #1;
    checks++; if (a_count !== 3'd0 || a_valid !== 1'b0 || b_valid !== 1'b0) begin
      errors++; $display("FAIL post_reset_empty got cnt=%0d avld=%b bvld=%b exp 0 0 0", a_count, a_valid, b_valid);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    i_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      i_valid = 1'b1; i_data = 8'hC0 + 8'(i);
      @(posedge clk); #1;
    end
    i_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      i_data = 8'hC2 + 8'(i);
      @(negedge clk);
      checks++; if (a_count !== 3'd2 || a_valid !== 1'b1 || a_data !== 8'hC0 + 8'(i)) begin
        errors++; $display("FAIL b2b_a got cnt=%0d vld=%b data=%h exp 2 1 %h", a_count, a_valid, a_data, 8'hC0 + 8'(i));
      end
      checks++; if (b_count !== 3'd2 || b_valid !== 1'b1 || b_data !== 8'hC0 + 8'(i)) begin
        errors++; $display("FAIL b2b_b got cnt=%0d vld=%b data=%h exp 2 1 %h", b_count, b_valid, b_data, 8'hC0 + 8'(i));
      end
      @(posedge clk); #1;
    end
    i_valid = 1'b0;
  endtask

  task automatic test_random();
    logic [8:0] sent[$];
    logic [8:0] prev_beat = 9'h0;
    bit prev_stall = 1'b0;
    bit hold = 1'b0;
    bit exp_ready = 1'b1;
    bit exp_valid, acc, del;
    int delivered = 0;
    int cycles = 0;
    do_reset();
    while (delivered < 1000 && cycles < 20000) begin
      if (!hold) begin
        i_valid = 1'($urandom_range(0, 1));
        i_data  = 8'($urandom);
        i_last  = 1'($urandom_range(0, 1));
      end
      i_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      exp_valid = (sent.size() > 0) || (i_valid && exp_ready);
      checks++; if (int'(c_count) != sent.size() || c_count > 4'd8) begin
        errors++; $display("FAIL rand_count got %0d exp %0d", c_count, sent.size());
      end
      checks++; if (c_ready !== exp_ready || c_valid !== exp_valid) begin
        errors++; $display("FAIL rand_handshake got rdy=%b vld=%b exp %b %b", c_ready, c_valid, exp_ready, exp_valid);
      end
      if (prev_stall) begin
        checks++; if ({c_last, c_data} !== prev_beat) begin
          errors++; $display("FAIL rand_stall_stable got %h exp %h", {c_last, c_data}, prev_beat);
        end
      end
      acc = i_valid && exp_ready;
      del = exp_valid && i_ready;
      if (acc) sent.push_back({i_last, i_data});
      if (del && sent.size() > 0) begin
        checks++; if ({c_last, c_data} !== sent[0]) begin
          errors++; $display("FAIL rand_order got %h exp %h at beat %0d", {c_last, c_data}, sent[0], delivered);
        end
        void'(sent.pop_front());
        delivered++;
      end
      exp_ready  = (sent.size() < 8);
      prev_stall = exp_valid && !i_ready;
      prev_beat  = {c_last, c_data};
      hold       = i_valid && !acc;
      cycles++;
      @(posedge clk); #1;
    end
    i_valid = 1'b0;
    checks++; if (delivered < 1000) begin
      errors++; $display("FAIL rand_timeout got %0d beats exp 1000", delivered);
    end
  endtask

  initial begin
    test_reset();
    test_bypass();
    test_fill_drain();
    test_reg_out();
    test_async_reset();
    test_back_to_back();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/axis_elastic_buffer.md
AXIS_ELASTIC_BUFFER -- requirements
Module: axis_elastic_buffer

Interface
REQ-001 The block SHALL have parameter DWIDTH, default 8, data width in bits (>=1).
REQ-002 The block SHALL have parameter DEPTH, default 4, storage entries (power of two, >=2).
REQ-003 The block SHALL have parameter REG_OUT, default 0: 0 = zero-latency bypass when empty, 1 = all outputs driven from storage.
REQ-004 The block SHALL have port clk, input, 1, the single clock; all logic is on its rising edge.
REQ-005 The block SHALL have port rst, input, 1, reset, asynchronous and active-high.
REQ-006 The block SHALL have port i_data, input, DWIDTH, upstream data.
REQ-007 The block SHALL have port i_last, input, 1, upstream end-of-packet marker.
REQ-008 The block SHALL have port i_valid, input, 1, upstream valid.
REQ-009 The block SHALL have port o_ready, output, 1, ready to upstream, registered.
REQ-010 The block SHALL have port o_data, output, DWIDTH, downstream data.
REQ-011 The block SHALL have port o_last, output, 1, downstream end-of-packet marker.
REQ-012 The block SHALL have port o_valid, output, 1, downstream valid.
REQ-013 The block SHALL have port i_ready, input, 1, downstream ready.
REQ-014 The block SHALL have port o_count, output, $clog2(DEPTH+1), registered count of stored entries.

Function
REQ-015 The block SHALL accept an input beat when i_valid && o_ready, and deliver an output beat when o_valid && i_ready.
REQ-016 The block SHALL store {i_last, i_data} as one unit per entry, in a circular array with read/write pointers that wrap from DEPTH-1 to 0.
REQ-017 The block SHALL drive o_ready from a flop, equal to (next count < DEPTH), so there is no combinational path from i_ready to o_ready.
REQ-018 In REG_OUT=0 with count==0, the block SHALL drive o_valid = i_valid && o_ready, o_data = i_data and o_last = i_last combinationally (latency 0).
REQ-019 In REG_OUT=0, a beat accepted while count==0 and i_ready==1 SHALL pass through and SHALL NOT be written to storage; count SHALL stay 0.
REQ-020 In REG_OUT=0, a beat accepted while count==0 and i_ready==0 SHALL be written to storage, and count SHALL become 1.
REQ-021 When count>0, or when REG_OUT=1, the block SHALL drive o_valid = (count>0), and o_data/o_last SHALL come from the entry at the read pointer.
REQ-022 In REG_OUT=1, minimum latency from input to output SHALL be 1 cycle.
REQ-023 For simultaneous accept and deliver with count>0, count SHALL be unchanged and both pointers SHALL advance.
REQ-024 Order SHALL be strictly FIFO: beats SHALL NOT be lost, duplicated or reordered, with i_last preserved per beat.
REQ-025 At full (count==DEPTH), o_ready SHALL be 0.
REQ-026 At full, a deliver SHALL make o_ready 1 on the next cycle.
REQ-027 At empty with REG_OUT=1, o_valid SHALL be 0.
REQ-028 While o_valid==1 and i_ready==0, o_data and o_last SHALL be held stable.
REQ-029 o_count SHALL never exceed DEPTH and SHALL never go below 0.

Reset
REQ-030 While rst==1, the block SHALL hold count=0, pointers=0, o_ready=0, o_valid=0, o_count=0, o_data=0 and o_last=0, independent of clk.
REQ-031 Storage contents SHALL be don't-care after reset; no stale entry SHALL be visible.
REQ-032 o_ready SHALL rise at the first clk edge after rst deasserts.
REQ-033 Reset asserted mid-transfer SHALL discard all stored beats.

Verification
REQ-034 The bench SHALL cover: REG_OUT=0, DEPTH=4, i_ready=1, stream 0x01..0x08 -> each beat appears on o_data in the same cycle, o_count stays 0.
REQ-035 The bench SHALL cover: REG_OUT=0, i_ready=0, push 0xA0..0xA3 -> o_count=4, o_ready=0 next cycle, o_valid=1 with o_data=0xA0; then raise i_ready -> 0xA0..0xA3 in order, o_ready=1 one cycle after first deliver.
REQ-036 The bench SHALL cover: REG_OUT=1, i_ready=1, single beat 0x55 with i_last=1 -> o_valid=1, o_data=0x55, o_last=1 exactly one cycle later.
REQ-037 The bench SHALL cover: random i_valid/i_ready at 50% each, 1000 beats, DEPTH=8 -> scoreboard match, o_count within 0..8, no output change while stalled.
REQ-038 The bench SHALL cover: full buffer with rst pulsed asynchronously between edges -> o_valid/o_ready/o_count drop to 0 immediately; after release, first new beat 0x7F is output with no stale data.
REQ-039 The bench SHALL cover: count=2, simultaneous push and pop for 10 cycles -> o_count stays 2, pointers wrap correctly, order preserved.
